// File: rtl/jtag_tap_ctrl.sv
// TAP controller: 16-state 1149.1 FSM, IR, IDCODE/BYPASS DRs, TDO mux, boundary-chain strobes.
// Latency: outputs decode from the current state, valid one tck edge after the tms sample; tdo is combinational.
// Backpressure: none; the serial port advances on every tck edge.
module jtag_tap_ctrl #(
   parameter int          IR_WIDTH   = 4,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5D
) (
   input  logic                tck,
   input  logic                trst_n,
   input  logic                tms,
   input  logic                tdi,
   output logic                tdo,
   output logic                tdo_en,
   input  logic                bsr_tdo,
   output logic                bsr_capture,
   output logic                bsr_shift,
   output logic                bsr_update,
   output logic                bsr_mode,
   output logic [IR_WIDTH-1:0] instr,
   output logic                tlr
);

   typedef enum logic [3:0] {
      S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR,
      S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
   } tap_state_t;

   localparam logic [IR_WIDTH-1:0] IR_EXTEST  = '0;
   localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(2);
   // Fixed 01 pattern in the low bits lets a board-level tool find IR boundaries.
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

   tap_state_t          state;
   tap_state_t          state_nxt;
   logic [IR_WIDTH-1:0] ir_shift;
   logic [31:0]         id_shift;
   logic                bypass;
   logic                sel_bsr;
   logic                sel_id;
   logic                sel_byp;

   // Instruction decode: anything that is not a boundary or IDCODE op selects bypass.
   always_comb begin
      sel_bsr = (instr == IR_EXTEST) || (instr == IR_SAMPLE);
      sel_id  = (instr == IR_IDCODE);
      sel_byp = !sel_bsr && !sel_id;
   end

   // State register; trst_n overrides tms.
   always_ff @(posedge tck) begin
      if (!trst_n) state <= S_TLR;
      else         state <= state_nxt;
   end

   // Next-state from tms and Moore outputs decoded from the current state.
   always_comb begin
      state_nxt   = state;
      tdo         = 1'b0;
      tdo_en      = 1'b0;
      bsr_capture = 1'b0;
      bsr_shift   = 1'b0;
      bsr_update  = 1'b0;
      tlr         = (state == S_TLR);
      bsr_mode    = (instr == IR_EXTEST) && (state != S_TLR);
      case (state)
         S_TLR:    state_nxt = tms ? S_TLR    : S_RTI;
         S_RTI:    state_nxt = tms ? S_SEL_DR : S_RTI;
         S_SEL_DR: state_nxt = tms ? S_SEL_IR : S_CAP_DR;
         S_CAP_DR: begin
            state_nxt   = tms ? S_EX1_DR : S_SH_DR;
            bsr_capture = sel_bsr;
         end
         S_SH_DR: begin
            state_nxt = tms ? S_EX1_DR : S_SH_DR;
            tdo_en    = 1'b1;
            bsr_shift = sel_bsr;
            if (sel_id)       tdo = id_shift[0];
            else if (sel_byp) tdo = bypass;
            else              tdo = bsr_tdo;
         end
         S_EX1_DR: state_nxt = tms ? S_UPD_DR : S_PAU_DR;
         S_PAU_DR: state_nxt = tms ? S_EX2_DR : S_PAU_DR;
         S_EX2_DR: state_nxt = tms ? S_UPD_DR : S_SH_DR;
         S_UPD_DR: begin
            state_nxt  = tms ? S_SEL_DR : S_RTI;
            bsr_update = sel_bsr;
         end
         S_SEL_IR: state_nxt = tms ? S_TLR    : S_CAP_IR;
         S_CAP_IR: state_nxt = tms ? S_EX1_IR : S_SH_IR;
         S_SH_IR: begin
            state_nxt = tms ? S_EX1_IR : S_SH_IR;
            tdo_en    = 1'b1;
            tdo       = ir_shift[0];
         end
         S_EX1_IR: state_nxt = tms ? S_UPD_IR : S_PAU_IR;
         S_PAU_IR: state_nxt = tms ? S_EX2_IR : S_PAU_IR;
         S_EX2_IR: state_nxt = tms ? S_UPD_IR : S_SH_IR;
         S_UPD_IR: state_nxt = tms ? S_SEL_DR : S_RTI;
         default:  state_nxt = S_TLR;
      endcase
   end

   // Capture/shift/update of IR and internal DRs; Pause/Exit states hold everything.
   always_ff @(posedge tck) begin
      if (!trst_n) begin
         instr    <= IR_IDCODE;
         ir_shift <= '0;
         id_shift <= '0;
         bypass   <= 1'b0;
      end else begin
         case (state)
            S_TLR: begin
               instr    <= IR_IDCODE;
               ir_shift <= '0;
               id_shift <= '0;
               bypass   <= 1'b0;
            end
            S_CAP_DR: begin
               if (sel_id)       id_shift <= IDCODE_VAL;
               else if (sel_byp) bypass   <= 1'b0;
            end
            S_SH_DR: begin
               if (sel_id)       id_shift <= {tdi, id_shift[31:1]};
               else if (sel_byp) bypass   <= tdi;
            end
            S_CAP_IR: ir_shift <= IR_CAPTURE;
            S_SH_IR:  ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
            S_UPD_IR: instr    <= ir_shift;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: directed TAP sequences then random tms/tdi/trst against a queue-based model.
// Latency: expectation pushed 1 time unit after each posedge, compared on the following negedge.
// Backpressure: none; one expectation per tck cycle.
module tb_jtag_tap_ctrl;

   localparam int          IRW   = 4;
   localparam logic [31:0] IDVAL = 32'h1000_0A5D;

   logic           tck = 1'b0;
   logic           trst_n = 1'b0;
   logic           tms = 1'b1;
   logic           tdi = 1'b0;
   logic           bsr_tdo = 1'b0;
   logic           tdo, tdo_en, bsr_capture, bsr_shift, bsr_update, bsr_mode, tlr;
   logic [IRW-1:0] instr;

   jtag_tap_ctrl #(.IR_WIDTH(IRW), .IDCODE_VAL(IDVAL)) dut (
      .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
      .bsr_tdo(bsr_tdo), .bsr_capture(bsr_capture), .bsr_shift(bsr_shift),
      .bsr_update(bsr_update), .bsr_mode(bsr_mode), .instr(instr), .tlr(tlr)
   );

   always #5 tck = ~tck;

   // ---------------- reference model ----------------
   string    nx0[string];
   string    nx1[string];
   string    ms;
   bit       irq[$];
   bit       idq[$];
   bit       byp;
   logic [3:0] m_instr;
   logic [10:0] exp_q[$];
   int       n_vec = 0;
   int       n_bad = 0;

   task automatic init_tables();
      nx0["TLR"]="RTI";     nx1["TLR"]="TLR";
      nx0["RTI"]="RTI";     nx1["RTI"]="SelDR";
      nx0["SelDR"]="CapDR"; nx1["SelDR"]="SelIR";
      nx0["CapDR"]="ShDR";  nx1["CapDR"]="Ex1DR";
      nx0["ShDR"]="ShDR";   nx1["ShDR"]="Ex1DR";
      nx0["Ex1DR"]="PauDR"; nx1["Ex1DR"]="UpdDR";
      nx0["PauDR"]="PauDR"; nx1["PauDR"]="Ex2DR";
      nx0["Ex2DR"]="ShDR";  nx1["Ex2DR"]="UpdDR";
      nx0["UpdDR"]="RTI";   nx1["UpdDR"]="SelDR";
      nx0["SelIR"]="CapIR"; nx1["SelIR"]="TLR";
      nx0["CapIR"]="ShIR";  nx1["CapIR"]="Ex1IR";
      nx0["ShIR"]="ShIR";   nx1["ShIR"]="Ex1IR";
      nx0["Ex1IR"]="PauIR"; nx1["Ex1IR"]="UpdIR";
      nx0["PauIR"]="PauIR"; nx1["PauIR"]="Ex2IR";
      nx0["Ex2IR"]="ShIR";  nx1["Ex2IR"]="UpdIR";
      nx0["UpdIR"]="RTI";   nx1["UpdIR"]="SelDR";
   endtask

   function automatic string reg_kind(input logic [3:0] i);
      if (i == 4'b0000 || i == 4'b0001) return "BSR";
      if (i == 4'b0010) return "ID";
      return "BYP";
   endfunction

   task automatic model_clear();
      irq.delete(); idq.delete();
      repeat (IRW) irq.push_back(1'b0);
      repeat (32)  idq.push_back(1'b0);
      byp = 1'b0;
      m_instr = 4'b0010;
   endtask

   task automatic model_edge(input bit t_tms, input bit t_tdi, input bit t_trst);
      string k;
      if (!t_trst) begin
         ms = "TLR";
         model_clear();
         return;
      end
      k = reg_kind(m_instr);
      if (ms == "TLR") model_clear();
      else if (ms == "CapDR") begin
         if (k == "ID") begin
            idq.delete();
            for (int i = 0; i < 32; i++) idq.push_back(IDVAL[i]);
         end else if (k == "BYP") byp = 1'b0;
      end else if (ms == "ShDR") begin
         if (k == "ID") begin
            void'(idq.pop_front());
            idq.push_back(t_tdi);
         end else if (k == "BYP") byp = t_tdi;
      end else if (ms == "CapIR") begin
         irq.delete();
         irq.push_back(1'b1);
         repeat (IRW-1) irq.push_back(1'b0);
      end else if (ms == "ShIR") begin
         void'(irq.pop_front());
         irq.push_back(t_tdi);
      end else if (ms == "UpdIR") begin
         for (int i = 0; i < IRW; i++) m_instr[i] = irq[i];
      end
      ms = t_tms ? nx1[ms] : nx0[ms];
   endtask

   function automatic logic [10:0] model_out(input logic cur_bsr_tdo);
      string k;
      logic  e_tdo, e_en, e_cap, e_sh, e_upd, e_mode, e_tlr;
      k      = reg_kind(m_instr);
      e_tlr  = (ms == "TLR");
      e_en   = (ms == "ShDR") || (ms == "ShIR");
      e_cap  = (ms == "CapDR") && (k == "BSR");
      e_sh   = (ms == "ShDR")  && (k == "BSR");
      e_upd  = (ms == "UpdDR") && (k == "BSR");
      e_mode = (m_instr == 4'b0000) && !e_tlr;
      e_tdo  = 1'b0;
      if (ms == "ShIR") e_tdo = irq[0];
      else if (ms == "ShDR") begin
         if (k == "ID")       e_tdo = idq[0];
         else if (k == "BYP") e_tdo = byp;
         else                 e_tdo = cur_bsr_tdo;
      end
      return {m_instr, e_tlr, e_mode, e_upd, e_sh, e_cap, e_en, e_tdo};
   endfunction

   // ---------------- stimulus ----------------
   task automatic tick(input bit t_tms, input bit t_tdi, input bit t_trst);
      tms = t_tms; tdi = t_tdi; trst_n = t_trst;
      @(posedge tck); #1;
      model_edge(t_tms, t_tdi, t_trst);
      bsr_tdo = 1'($urandom_range(0, 1));
      exp_q.push_back(model_out(bsr_tdo));
   endtask

   task automatic step(input bit t_tms, input bit t_tdi);
      tick(t_tms, t_tdi, 1'b1);
   endtask

   // From RTI: shift a full IR, update, return to RTI.
   task automatic load_ir(input logic [3:0] code);
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < IRW; i++) step(i == IRW-1, code[i]);
      step(1, 0); step(0, 0);
   endtask

   // From RTI: DR scan of n bits taken LSB-first from pat, update, return to RTI.
   task automatic scan_dr(input int n, input logic [31:0] pat);
      step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < n; i++) step(i == n-1, pat[i]);
      step(1, 0); step(0, 0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge tck) begin
      logic [10:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {instr, tlr, bsr_mode, bsr_update, bsr_shift, bsr_capture, tdo_en, tdo};
         n_vec++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL vec%0d t=%0t {instr,tlr,mode,upd,sh,cap,en,tdo} got %b exp %b",
                     n_vec, $time, a, e);
         end
      end
   end

   initial begin
      init_tables();
      ms = "TLR";
      model_clear();
      // reset for two edges
      tick(1, 0, 0); tick(1, 0, 0);
      // IDCODE read: 0,1,0,0 then 32 shifts, last leaves ShDR
      step(0, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 32; i++) step(i == 31, 1'($urandom_range(0, 1)));
      step(1, 0); step(0, 0);
      // sticky reset from ShDR
      step(1, 0); step(0, 0); step(0, 0); step(0, 1);
      repeat (5) step(1, 0);
      // load BYPASS, then abort an IR scan from PauIR
      step(0, 0);
      load_ir(4'b1111);
      step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(1, 0); step(0, 0);
      repeat (5) step(1, 0);
      step(0, 0);
      // BYPASS with pattern 1011
      load_ir(4'b1111);
      scan_dr(4, 32'b1101);
      // EXTEST
      load_ir(4'b0000);
      scan_dr(8, $urandom);
      repeat (5) step(1, 0);
      step(0, 0);
      // undefined code and SAMPLE
      load_ir(4'b0101);
      scan_dr(6, $urandom);
      load_ir(4'b0001);
      scan_dr(5, $urandom);
      // mid-scan trst
      load_ir(4'b0010);
      step(1, 0); step(0, 0); step(0, 0); step(0, 1);
      tick(0, 1, 0);
      step(0, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 32; i++) step(i == 31, 1'($urandom_range(0, 1)));
      step(1, 0); step(0, 0);
      // random walk
      for (int i = 0; i < 600; i++)
         tick(($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) >= 2));
      repeat (3) @(negedge tck);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1-style TAP controller for the soda_machine test port. It sequences the 16-state TAP FSM from `tms` and owns the instruction register, the IDCODE and BYPASS data registers, and the TDO mux. It also generates the capture, shift and update strobes that drive the external boundary-scan chain around the n/d/q inputs and the n_out/d_out/dispense outputs. Everything runs in the `tck` domain.

## Interface
Parameters:
- `IR_WIDTH`, default 4: instruction register width (≥ 2).
- `IDCODE_VAL`, default 32'h1000_0A5D: value captured by IDCODE. Bit 0 must be 1.

Ports:
- `tck` in 1: test clock. This is the only clock.
- `trst_n` in 1: reset, synchronous, active-low, sampled on posedge `tck`.
- `tms` in 1: test mode select.
- `tdi` in 1: serial data in.
- `tdo` out 1: serial data out.
- `tdo_en` out 1: high only in Shift-DR and Shift-IR.
- `bsr_tdo` in 1: serial output of the external boundary chain.
- `bsr_capture` out 1: boundary chain capture strobe.
- `bsr_shift` out 1: boundary chain shift strobe.
- `bsr_update` out 1: boundary chain update strobe.
- `bsr_mode` out 1: 1 means the core pins are driven from the boundary update latches (EXTEST).
- `instr` out IR_WIDTH: current (updated) instruction.
- `tlr` out 1: high while the FSM is in Test-Logic-Reset.

## Operation
- FSM states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR.
- Transitions follow 1149.1 exactly. Examples: TLR goes to TLR on tms=1 and to RTI on tms=0. SelIR goes to TLR on tms=1. UpdDR and UpdIR go to SelDR on tms=1 and to RTI on tms=0.
- Reset:
  - `trst_n`=0 at a posedge forces TLR.
  - TLR also sets `instr`=IDCODE (4'b0010) and clears all shift registers.
  - Five consecutive tms=1 edges reach TLR from any state.
- Instructions:
  - 4'b0000 EXTEST
  - 4'b0001 SAMPLE
  - 4'b0010 IDCODE
  - 4'b1111 BYPASS
  - Every other code decodes as BYPASS.
- Each DR action below happens on the posedge at which the FSM is in the named state.
- CapDR:
  - IDCODE: 32-bit DR ← IDCODE_VAL.
  - BYPASS: bypass bit ← 0.
  - EXTEST/SAMPLE: `bsr_capture`=1 during the state.
- ShDR: the selected register shifts right, with `tdi` into the MSB. `bsr_shift`=1 for EXTEST/SAMPLE.
- UpdDR: `bsr_update`=1 for EXTEST/SAMPLE.
- IR actions:
  - CapIR: IR shift register ← {0…0,2'b01}.
  - ShIR: the IR shift register shifts right, with `tdi` into the MSB.
  - UpdIR: `instr` ← IR shift register.
- `bsr_mode` = (`instr`==EXTEST) && !`tlr`.
- `tdo` is combinational. Its source depends on the state and `instr`:
  - ShIR: the IR shift register LSB.
  - ShDR with IDCODE: the IDCODE shift register LSB.
  - ShDR with BYPASS: the bypass bit.
  - ShDR with EXTEST/SAMPLE: `bsr_tdo`.
  - Any other state: 0.
- In Pause and Exit states no register changes.

## Timing
- Values after reset (first posedge with `trst_n`=0):
  - state=TLR, `tlr`=1.
  - `instr`=4'b0010.
  - `tdo`=0, `tdo_en`=0.
  - All `bsr_*` strobes=0.
- State register updates on posedge `tck`. Every output is decoded from the current state, so each one is valid one edge after the tms sample that caused it.
- Each strobe is high for exactly one `tck` cycle per visit to CapDR or UpdDR. `bsr_shift` stays high for every cycle spent in ShDR.
- Latency from TLR:
  - To the first IDCODE bit on `tdo`: tms sequence 0,1,0,0. After the 4th edge the FSM is in ShDR and `tdo`=IDCODE_VAL[0].
  - BYPASS gives a 1-cycle `tdi`→`tdo` delay.
- Leaving ShDR on the 32nd shift edge (tms=1) shifts that final bit.
- `instr` changes only in UpdIR or TLR. An aborted IR scan (through TLR) never applies the partial value.
- A `trst_n` assertion mid-scan wins over tms and discards shift contents.

## Test plan
- Reset: hold `trst_n`=0 for 2 edges → `tlr`=1, `instr`=4'b0010, `tdo_en`=0, all strobes 0.
- IDCODE read: tms 0,1,0,0, then 32 edges in ShDR → `tdo` serializes 32'h1000_0A5D LSB-first. `tdo_en`=1 throughout.
- Sticky reset: from ShDR and from PauIR, apply tms=1 ×5 → `tlr`=1 and `instr`=IDCODE, checked at both starting points.
- IR capture and BYPASS:
  - Load IR through ShIR with `tdi`=1111 → the first 4 `tdo` bits read 1,0,0,0.
  - After UpdIR `instr`=4'b1111.
  - A DR shift of `tdi` pattern 1011 appears on `tdo` delayed by 1 cycle, with first bit 0.
- EXTEST:
  - Load 4'b0000 → `bsr_mode`=1.
  - A DR scan gives `bsr_capture` as a 1-cycle pulse in CapDR, `bsr_shift` high for N cycles, and a `bsr_update` pulse in UpdDR.
  - `tdo` follows `bsr_tdo`.
  - Five tms=1 edges → `bsr_mode`=0.
- Undefined code: load 4'b0101 → it behaves as BYPASS (1-bit delay) and `bsr_mode`=0.
